// File: rtl/spi_link_master.sv
// rtl/spi_link_master.sv - host-side SPI link command initiator, stop-and-wait over a byte SPI engine
module spi_link_master #(
    parameter int GAP_CYCLES   = 0,
    parameter int ECHO_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [6:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    input  logic [15:0] cmd_len,
    input  logic [7:0]  pay_data,
    input  logic        pay_valid,
    output logic        pay_ready,
    output logic [7:0]  byte_out,
    output logic        byte_out_valid,
    input  logic        byte_out_ready,
    input  logic [7:0]  byte_in,
    input  logic        byte_in_valid,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, SEND, WAIT_ECHO, PAYLOAD, GAP} state_t;

    localparam logic [15:0] TO_LAST  = 16'(ECHO_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam state_t      END_ST   = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t      state, state_n;
    logic [1:0]  op_q;
    logic [6:0]  addr_q;
    logic [7:0]  data_q;
    logic [15:0] len_q;
    logic [1:0]  idx;
    logic [15:0] pay_cnt;
    logic        pay_last;
    logic [15:0] to_cnt;
    logic [15:0] gap_cnt;

    logic [1:0]  hdr_len, idx_inc;
    logic [7:0]  hdr_byte;
    logic        accept, handshake, echo, timeout, pay_take, hdr_phase;
    logic        echo_last, echo_to_pay;

    // idx counts echoed header bytes; once it reaches hdr_len only payload remains
    always_comb begin
        hdr_len   = (op_q == 2'd0) ? 2'd2 : 2'd3;
        idx_inc   = idx + 2'd1;
        hdr_phase = (idx < hdr_len);
        hdr_byte  = 8'h00;
        case (idx)
            2'd0: hdr_byte = (op_q == 2'd0) ? 8'h87 : (op_q == 2'd1) ? 8'h88 : 8'h89;
            2'd1: case (op_q)
                      2'd0:    hdr_byte = data_q;
                      2'd1:    hdr_byte = len_q[7:0];
                      2'd2:    hdr_byte = {1'b1, addr_q};
                      default: hdr_byte = {1'b0, addr_q};
                  endcase
            2'd2: case (op_q)
                      2'd1:    hdr_byte = len_q[15:8];
                      2'd2:    hdr_byte = data_q;
                      default: hdr_byte = 8'h00;
                  endcase
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        accept      = cmd_valid && (state == IDLE);
        handshake   = (state == SEND) && byte_out_valid && byte_out_ready;
        echo        = (state == WAIT_ECHO) && byte_in_valid;
        timeout     = (state == WAIT_ECHO) && !byte_in_valid && (ECHO_TIMEOUT != 0) && (to_cnt == TO_LAST);
        pay_take    = (state == PAYLOAD) && pay_valid;
        echo_last   = echo && (hdr_phase ? (idx_inc == hdr_len && op_q != 2'd1) : pay_last);
        echo_to_pay = echo && (op_q == 2'd1) && (hdr_phase ? (idx_inc == hdr_len) : !pay_last);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (accept) state_n = SEND;
            SEND:      if (handshake) state_n = WAIT_ECHO;
            WAIT_ECHO: if (echo_last || timeout) state_n = END_ST;
                       else if (echo_to_pay)     state_n = PAYLOAD;
                       else if (echo)            state_n = SEND;
            PAYLOAD:   if (pay_take) state_n = SEND;
            GAP:       if (gap_cnt == GAP_LAST) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state == SEND) || (state == WAIT_ECHO) || (state == PAYLOAD);
        pay_ready = (state == PAYLOAD);
        err       = timeout;
    end

    // Header bytes load on SEND entry; payload bytes arrive already valid from PAYLOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0; addr_q <= '0; data_q <= '0; len_q <= '0;
            idx <= '0; pay_cnt <= '0; pay_last <= 1'b0; to_cnt <= '0; gap_cnt <= '0;
            byte_out <= '0; byte_out_valid <= 1'b0; rd_data <= '0; rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            gap_cnt  <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
            if (accept) begin
                op_q <= cmd_op; addr_q <= cmd_addr; data_q <= cmd_data; len_q <= cmd_len;
                idx <= '0; pay_cnt <= '0; pay_last <= 1'b0;
            end
            if (state == SEND && !byte_out_valid) begin
                byte_out       <= hdr_byte;
                byte_out_valid <= 1'b1;
            end
            if (handshake) begin
                byte_out_valid <= 1'b0;
                to_cnt         <= '0;
            end
            if (state == WAIT_ECHO) to_cnt <= to_cnt + 16'd1;
            if (echo && hdr_phase) idx <= idx_inc;
            if (echo && op_q == 2'd3 && idx == 2'd2) begin
                rd_data  <= byte_in;
                rd_valid <= 1'b1;
            end
            if (pay_take) begin
                byte_out       <= pay_data;
                byte_out_valid <= 1'b1;
                pay_last       <= (pay_cnt == len_q);
                pay_cnt        <= pay_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_spi_link_master.sv
// tb/tb_spi_link_master.sv - randomized bench for spi_link_master against a byte-sequence model
module tb_spi_link_master;
    localparam int GAP = 2;
    localparam int TO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [15:0] cmd_len;
    logic [7:0]  pay_data;
    logic        pay_valid, pay_ready;
    logic [7:0]  byte_out;
    logic        byte_out_valid, byte_out_ready;
    logic [7:0]  byte_in;
    logic        byte_in_valid;
    logic [7:0]  rd_data;
    logic        rd_valid, busy, err;

    spi_link_master #(.GAP_CYCLES(GAP), .ECHO_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_len(cmd_len),
        .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
        .byte_out(byte_out), .byte_out_valid(byte_out_valid), .byte_out_ready(byte_out_ready),
        .byte_in(byte_in), .byte_in_valid(byte_in_valid),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, cyc = 0;
    logic [7:0] sent[$], exp_q[$], echo_q[$], pay_q[$];
    int echo_cnt = 0, echo_dly = 0, hold_low = 0, rdy_pct = 100, pay_pct = 70;
    int n_hs, withhold_at = 0, withhold_hs_cyc, n_rd, n_err, err_cyc, last_echo_cyc;
    int busy_fall, ready_rise, stab_err, overlap_err;
    logic [7:0] rd_seen;
    logic p_valid = 0, p_ready = 0, p_busy = 0, p_cmd_ready = 0;
    logic [7:0] p_byte = 0;
    bit junk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive just after the rising edge, observe at the falling edge what the next edge will see
    task automatic tick();
        @(posedge clk);
        #1;
        byte_in_valid = 1'b0;
        byte_in       = 8'($urandom);
        if (echo_cnt > 0) begin
            echo_cnt--;
            if (echo_cnt == 0) begin
                byte_in_valid = 1'b1;
                if (echo_q.size() > 0) byte_in = echo_q.pop_front();
            end
        end
        byte_out_ready = (hold_low > 0) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
        pay_valid      = (pay_q.size() > 0) && ($urandom_range(0, 99) < pay_pct);
        pay_data       = (pay_q.size() > 0) ? pay_q[0] : 8'($urandom);
        @(negedge clk);
        cyc++;
        if (byte_in_valid) last_echo_cyc = cyc;
        if (p_valid && !p_ready && (!byte_out_valid || byte_out != p_byte)) stab_err++;
        if (pay_ready && byte_out_valid) overlap_err++;
        if (byte_out_valid && byte_out_ready) begin
            sent.push_back(byte_out);
            n_hs++;
            if (n_hs == withhold_at) withhold_hs_cyc = cyc;
            else echo_cnt = (echo_dly > 0) ? echo_dly : $urandom_range(1, 6);
        end
        if (pay_valid && pay_ready) void'(pay_q.pop_front());
        if (rd_valid) begin n_rd++; rd_seen = rd_data; end
        if (err) begin n_err++; err_cyc = cyc; end
        if (p_busy && !busy) busy_fall = cyc;
        if (!p_cmd_ready && cmd_ready) ready_rise = cyc;
        p_valid = byte_out_valid; p_ready = byte_out_ready; p_byte = byte_out;
        p_busy = busy; p_cmd_ready = cmd_ready;
        if (hold_low > 0) hold_low--;
    endtask

    task automatic start_cmd(input logic [1:0] op, input logic [6:0] addr, input logic [7:0] data,
                             input logic [15:0] len, input logic [7:0] pbase, input logic [7:0] rdv,
                             input int wh);
        int w;
        exp_q.delete(); pay_q.delete(); echo_q.delete(); sent.delete();
        case (op)
            2'd0: begin exp_q.push_back(8'h87); exp_q.push_back(data); end
            2'd1: begin
                exp_q.push_back(8'h88); exp_q.push_back(len[7:0]); exp_q.push_back(len[15:8]);
                for (int i = 0; i <= int'(len); i++) begin
                    exp_q.push_back(8'(int'(pbase) + i));
                    pay_q.push_back(8'(int'(pbase) + i));
                end
            end
            2'd2: begin exp_q.push_back(8'h89); exp_q.push_back({1'b1, addr}); exp_q.push_back(data); end
            default: begin
                exp_q.push_back(8'h89); exp_q.push_back({1'b0, addr}); exp_q.push_back(8'h00);
                echo_q.push_back(8'hEE); echo_q.push_back(8'hEE); echo_q.push_back(rdv);
            end
        endcase
        n_hs = 0; n_rd = 0; n_err = 0; stab_err = 0; overlap_err = 0;
        withhold_at = wh; withhold_hs_cyc = -1; err_cyc = -1; last_echo_cyc = -1;
        busy_fall = -1; ready_rise = -1;
        w = 0;
        while (!cmd_ready && w < 100) begin tick(); w++; end
        chk("cmd_ready_before", 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_len = len; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("busy_after_accept", {30'd0, busy, cmd_ready}, 32'd2);
    endtask

    task automatic finish_cmd(input string tag, input logic [1:0] op, input logic [7:0] rdv, input int wh);
        int w;
        w = 0;
        while (!cmd_ready && w < 10000) begin
            cmd_valid = junk && busy && ($urandom_range(0, 1) == 1);
            cmd_op = 2'($urandom); cmd_addr = 7'($urandom); cmd_data = 8'($urandom); cmd_len = 16'($urandom);
            tick();
            w++;
        end
        cmd_valid = 1'b0;
        chk({tag, "_done"}, 32'(cmd_ready), 32'd1);
        while (wh > 0 && exp_q.size() > wh) void'(exp_q.pop_back());
        chk({tag, "_nbytes"}, 32'(sent.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sent.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(sent[i]), 32'(exp_q[i]));
        chk({tag, "_nrd"}, 32'(n_rd), (op == 2'd3 && wh == 0) ? 32'd1 : 32'd0);
        if (op == 2'd3 && wh == 0) chk({tag, "_rd_data"}, 32'(rd_seen), 32'(rdv));
        chk({tag, "_nerr"}, 32'(n_err), (wh > 0) ? 32'd1 : 32'd0);
        if (wh > 0) chk({tag, "_err_cyc"}, 32'(err_cyc), 32'(withhold_hs_cyc + TO));
        chk({tag, "_busy_fall"}, 32'(busy_fall), 32'(((wh > 0) ? err_cyc : last_echo_cyc) + 1));
        chk({tag, "_ready_rise"}, 32'(ready_rise), 32'(busy_fall + GAP));
        chk({tag, "_stable"}, 32'(stab_err), 32'd0);
        chk({tag, "_pay_overlap"}, 32'(overlap_err), 32'd0);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [6:0] addr,
                           input logic [7:0] data, input logic [15:0] len, input logic [7:0] pbase,
                           input logic [7:0] rdv, input int wh);
        start_cmd(op, addr, data, len, pbase, rdv, wh);
        finish_cmd(tag, op, rdv, wh);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n0;
        logic [7:0] rv;
        rst = 1'b1; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; cmd_len = 0;
        pay_data = 0; pay_valid = 0; byte_out_ready = 0; byte_in = 0; byte_in_valid = 0;
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_pay_ready", 32'(pay_ready), 32'd0);
        chk("rst_bo_valid", 32'(byte_out_valid), 32'd0);
        chk("rst_byte_out", 32'(byte_out), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        rdy_pct = 100; echo_dly = 2;
        run_cmd("op0", 2'd0, 7'd0, 8'h5A, 16'd0, 8'd0, 8'd0, 0);

        rdy_pct = 70; echo_dly = 0; pay_pct = 60;
        run_cmd("op1", 2'd1, 7'd0, 8'd0, 16'h0102, 8'd0, 8'd0, 0);

        rdy_pct = 100; echo_dly = 2;
        run_cmd("op3", 2'd3, 7'h15, 8'd0, 16'd0, 8'd0, 8'hC3, 0);

        hold_low = 12;
        run_cmd("op2_hold", 2'd2, 7'h7F, 8'h00, 16'd0, 8'd0, 8'd0, 0);

        run_cmd("timeout", 2'd3, 7'h15, 8'd0, 16'd0, 8'd0, 8'h11, 2);
        run_cmd("after_to", 2'd0, 7'd0, 8'hA5, 16'd0, 8'd0, 8'd0, 0);

        junk = 1; echo_dly = 0;
        for (int k = 0; k < 12; k++) begin
            rdy_pct = $urandom_range(30, 100);
            pay_pct = $urandom_range(30, 100);
            rv = 8'($urandom);
            run_cmd($sformatf("rnd%0d", k), 2'($urandom), 7'($urandom), 8'($urandom),
                    16'($urandom_range(0, 20)), 8'($urandom), rv, 0);
        end
        junk = 0;

        rdy_pct = 80;
        start_cmd(2'd1, 7'd0, 8'd0, 16'd50, 8'h40, 8'd0, 0);
        w = 0;
        while (sent.size() < 8 && w < 2000) begin tick(); w++; end
        chk("rst_mid_reached", 32'(sent.size() >= 8), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid_bo_valid", 32'(byte_out_valid), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        echo_cnt = 0; echo_q.delete(); pay_q.delete();
        n0 = sent.size();
        repeat (20) tick();
        chk("rst_mid_no_bytes", 32'(sent.size()), 32'(n0));
        run_cmd("post_rst", 2'd0, 7'd0, 8'h3C, 16'd0, 8'd0, 8'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_link_master.md
Name: spi_link_master

Overview:
- Host-side initiator for the SPI link command protocol. It turns single command requests into the opcode/argument/payload byte sequence that the FPGA-side link decoder expects.
- It drives a byte-level SPI master engine one byte at a time, in stop-and-wait fashion.
- It returns the SD register readback byte.
- Used in loopback benches and on a controller FPGA driving the DAW board.

Parameters:
- GAP_CYCLES, 0: minimum idle cycles after a command completes before cmd_ready reasserts.
- ECHO_TIMEOUT, 1023: maximum cycles to wait for byte_in_valid after a byte handshake before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle, command accepted on cmd_valid&&cmd_ready
- cmd_op  in  2  0=DAC reg write, 1=packet, 2=SD reg write, 3=SD reg read
- cmd_addr  in  7  SD register address (ops 2,3)
- cmd_data  in  8  DAC value (op 0) or SD write data (op 2)
- cmd_len  in  16  packet payload length minus one (op 1)
- pay_data  in  8  packet payload byte
- pay_valid  in  1  payload byte available
- pay_ready  out  1  payload byte consumed on pay_valid&&pay_ready
- byte_out  out  8  byte to SPI engine
- byte_out_valid  out  1  byte_out valid
- byte_out_ready  in  1  engine accepts byte
- byte_in  in  8  byte shifted in during the last transfer
- byte_in_valid  in  1  one-cycle pulse per completed transfer
- rd_data  out  8  SD readback value
- rd_valid  out  1  one-cycle pulse, rd_data valid
- busy  out  1  command in progress
- err  out  1  one-cycle pulse on echo timeout

Behaviour:
- Reset values: cmd_ready=1, pay_ready=0, byte_out_valid=0, byte_out=0, rd_valid=0, rd_data=0, busy=0, err=0, state IDLE.
- Reset mid-command aborts immediately. No further bytes are issued and the command is lost.
- On acceptance, latch all cmd_* fields. cmd_ready=0 and busy=1 from the next cycle.
- Byte sequences, issued in order:
  - op0: 0x87, cmd_data.
  - op1: 0x88, len[7:0], len[15:8], then len+1 payload bytes.
  - op2: 0x89, {1'b1,addr}, cmd_data.
  - op3: 0x89, {1'b0,addr}, 0x00 (dummy).
- States: IDLE -> SEND -> WAIT_ECHO -> (SEND | PAYLOAD | DONE) -> GAP -> IDLE.
- SEND:
  - Register byte_out and raise byte_out_valid the cycle after entry.
  - Hold both stable until byte_out_ready. The handshake cycle drops valid on the next edge.
- WAIT_ECHO:
  - Wait for byte_in_valid. The next byte is never presented before the echo of the previous one.
  - byte_in_valid outside WAIT_ECHO is ignored.
- PAYLOAD:
  - pay_ready=1 only while no byte is pending to the engine.
  - On pay_valid&&pay_ready, the byte becomes byte_out (SEND path), then WAIT_ECHO.
  - A 16-bit counter counts payload bytes. The last payload byte is the one where counter==cmd_len.
  - pay_valid low stalls indefinitely, with no timeout.
  - cmd_len=0xFFFF sends 65536 bytes with no counter overflow misbehaviour.
- op3 readback:
  - byte_in captured with the echo of the dummy (3rd) byte -> rd_data.
  - rd_valid pulses the cycle after that byte_in_valid.
  - Echoes of the first two bytes are discarded.
- Timeout:
  - 16-bit counter, cleared at each byte handshake, counts in WAIT_ECHO.
  - Reaching ECHO_TIMEOUT pulses err, aborts the command with no rd_valid, and goes to GAP.
  - ECHO_TIMEOUT=0 disables the timeout.
- DONE/GAP:
  - busy=0 the cycle after the last echo.
  - cmd_ready reasserts after GAP_CYCLES further cycles (GAP_CYCLES=0: same cycle busy drops).
- cmd_valid while busy is ignored (not queued).
- pay_valid outside op1 PAYLOAD is ignored, with pay_ready=0.

Test Plan:
- op0 cmd_data=0x5A, engine ready=1, echo 2 cycles after each handshake -> byte_out sequence 0x87,0x5A; busy drops after 2nd echo; no rd_valid.
- op1 cmd_len=0x0102, payload 0..0x102 with random pay_valid gaps -> bytes 0x88,0x02,0x01, then exactly 259 payload bytes in order; pay_ready never high while byte_out_valid=1.
- op3 addr=0x15, engine returns 0xEE,0xEE,0xC3 -> bytes 0x89,0x15,0x00; rd_data=0xC3 with a single rd_valid pulse.
- op2 addr=0x7F data=0x00 with byte_out_ready held low 10 cycles -> byte_out/valid stable throughout; sequence 0x89,0xFF,0x00.
- ECHO_TIMEOUT=8, withhold echo after 2nd byte of op3 -> err pulse exactly 8 cycles after handshake; no rd_valid; next command accepted normally.
- rst asserted mid-payload of op1 -> byte_out_valid=0 and cmd_ready=1 the next cycle; a fresh op0 then sends 0x87,data correctly.
